// File: rtl/smul_sched.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : smul_sched
//  Purpose  : Round-robin scheduler that time-shares one comparator/Sobol
//             stochastic multiplier between two operand requesters. Each job
//             is aligned to the multiplier's free-running sequence phase, the
//             output bitstream is counted over a 2^LOG_WIN cycle window and a
//             ones-count plus scaled product are returned with the owner id.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk, rst_n               clock, asynchronous active-low reset (shared
//                             with the multiplier so the phase stays aligned)
//    reqN_valid/_a/_b         requester N operand pair offer
//    reqN_ready               requester N job accepted this cycle
//    mul_iA, mul_iB           operand bus to the multiplier
//    mul_loadA, mul_loadB     one-cycle operand load strobes
//    mul_oC                   multiplier output bitstream
//    res_valid/res_ready      result handshake
//    res_id                   requester that owns the result
//    res_cnt                  raw ones-count over the window
//    res_prod                 scaled (saturating) product
// ============================================================================
module smul_sched #(
    parameter int WIDTH   = 8,
    parameter int LOG_WIN = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req0_valid,
    input  logic [WIDTH-1:0]   req0_a,
    input  logic [WIDTH-1:0]   req0_b,
    output logic               req0_ready,
    input  logic               req1_valid,
    input  logic [WIDTH-1:0]   req1_a,
    input  logic [WIDTH-1:0]   req1_b,
    output logic               req1_ready,
    output logic [WIDTH-1:0]   mul_iA,
    output logic [WIDTH-1:0]   mul_iB,
    output logic               mul_loadA,
    output logic               mul_loadB,
    input  logic               mul_oC,
    output logic               res_valid,
    input  logic               res_ready,
    output logic               res_id,
    output logic [LOG_WIN:0]   res_cnt,
    output logic [WIDTH-1:0]   res_prod
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ARM  = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [LOG_WIN-1:0] C_PH_MAX = {LOG_WIN{1'b1}};
    localparam logic [LOG_WIN-1:0] C_PH_ONE = {{(LOG_WIN-1){1'b0}}, 1'b1};

    state_t              state_q;
    state_t              state_d;
    logic [LOG_WIN-1:0]  ph_q;
    logic [LOG_WIN-1:0]  ph_d;
    logic [LOG_WIN:0]    cnt_q;
    logic [WIDTH-1:0]    a_q;
    logic [WIDTH-1:0]    b_q;
    logic [WIDTH-1:0]    prod_q;
    logic                id_q;
    logic                rr_q;      // id served last; resets to 1 so req0 wins first
    logic                load_q;
    logic                valid_q;

    logic                w_ph_max;
    logic                w_grant0;
    logic                w_grant1;
    logic                w_accept;
    logic                w_res_hs;
    logic [LOG_WIN:0]    w_cnt_inc;
    logic [WIDTH-1:0]    w_prod_final;

    // ------------------------------------------------------------------
    // Arbitration and handshakes
    // ------------------------------------------------------------------
    assign ph_d     = ph_q + C_PH_ONE;
    assign w_ph_max = (ph_q == C_PH_MAX);

    // On contention the requester that was not served last wins.
    assign w_grant0 = req0_valid & (~req1_valid | rr_q);
    assign w_grant1 = req1_valid & (~req0_valid | ~rr_q);

    // Gated by rst_n so no ready leaks out while reset is held.
    assign req0_ready = rst_n & (state_q == S_IDLE) & w_grant0;
    assign req1_ready = rst_n & (state_q == S_IDLE) & w_grant1;
    assign w_accept   = req0_ready | req1_ready;
    assign w_res_hs   = valid_q & res_ready;

    // Count including the current sample; used for the last RUN cycle so the
    // product reflects the full window.
    assign w_cnt_inc    = cnt_q + {{LOG_WIN{1'b0}}, mul_oC};
    assign w_prod_final = w_cnt_inc[LOG_WIN] ? {WIDTH{1'b1}}
                                             : w_cnt_inc[LOG_WIN-1 -: WIDTH];

    // ------------------------------------------------------------------
    // Next-state decode
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (w_accept) state_d = S_ARM;
            // Loading at ph==MAX means the multiplier buffers hold the new
            // operands from ph==0, the start of its sequence.
            S_ARM:   if (w_ph_max) state_d = S_RUN;
            S_RUN:   if (w_ph_max) state_d = S_DONE;
            S_DONE:  if (w_res_hs) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // State, phase and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            ph_q    <= '0;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            prod_q  <= '0;
            id_q    <= 1'b0;
            rr_q    <= 1'b1;
            load_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ph_q    <= ph_d;
            // Registered strobe: high exactly in the ARM cycle with ph==MAX.
            load_q  <= (state_d == S_ARM) && (ph_d == C_PH_MAX);
            valid_q <= (state_d == S_DONE);

            if (w_accept) begin
                a_q  <= req1_ready ? req1_a : req0_a;
                b_q  <= req1_ready ? req1_b : req0_b;
                id_q <= req1_ready;
            end

            case (state_q)
                S_ARM: begin
                    if (w_ph_max) begin
                        cnt_q <= '0;
                    end
                end
                S_RUN: begin
                    cnt_q <= w_cnt_inc;
                    if (w_ph_max) begin
                        prod_q <= w_prod_final;
                    end
                end
                S_DONE: begin
                    if (w_res_hs) begin
                        rr_q <= id_q;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign mul_iA    = a_q;
    assign mul_iB    = b_q;
    assign mul_loadA = load_q;
    assign mul_loadB = load_q;
    assign res_valid = valid_q;
    assign res_id    = id_q;
    assign res_cnt   = cnt_q;
    assign res_prod  = prod_q;

endmodule
`default_nettype wire

// File: tb/tb_smul_sched.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_smul_sched
//  Purpose  : Directed self-checking bench for smul_sched (WIDTH=4,
//             LOG_WIN=8) with a behavioural model of the multiplier output.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_smul_sched;

    localparam int WIDTH   = 4;
    localparam int LOG_WIN = 8;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               req0_valid = 1'b0;
    logic [WIDTH-1:0]   req0_a = '0;
    logic [WIDTH-1:0]   req0_b = '0;
    logic               req0_ready;
    logic               req1_valid = 1'b0;
    logic [WIDTH-1:0]   req1_a = '0;
    logic [WIDTH-1:0]   req1_b = '0;
    logic               req1_ready;
    logic [WIDTH-1:0]   mul_iA;
    logic [WIDTH-1:0]   mul_iB;
    logic               mul_loadA;
    logic               mul_loadB;
    logic               mul_oC;
    logic               res_valid;
    logic               res_ready = 1'b0;
    logic               res_id;
    logic [LOG_WIN:0]   res_cnt;
    logic [WIDTH-1:0]   res_prod;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    logic [LOG_WIN-1:0] tb_ph;
    int oc_mode = 0;    // 0: constant 0, 1: constant 1, 2: toggling

    // Results of the stimulus helpers
    int   acc_cyc, acc_ph;
    bit   acc_ok, acc_r0, acc_r1;
    int   ld_cyc, ld_ph, n_loads, v_cyc;
    bit   ld_both, job_ok, saw_ready;
    logic [WIDTH-1:0] ld_a, ld_b;

    smul_sched #(.WIDTH(WIDTH), .LOG_WIN(LOG_WIN)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_ready (req1_ready),
        .mul_iA     (mul_iA),
        .mul_iB     (mul_iB),
        .mul_loadA  (mul_loadA),
        .mul_loadB  (mul_loadB),
        .mul_oC     (mul_oC),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_id     (res_id),
        .res_cnt    (res_cnt),
        .res_prod   (res_prod)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference phase: same reset net and same clock as the multiplier.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) tb_ph <= '0;
        else        tb_ph <= tb_ph + 8'd1;
    end

    assign mul_oC = (oc_mode == 1) ? 1'b1 : (oc_mode == 2) ? tb_ph[0] : 1'b0;

    // Offer an operand pair and wait for either ready; scramble operands after
    // the accept cycle so latching is exercised.
    task automatic issue(input int id, input logic [WIDTH-1:0] a,
                         input logic [WIDTH-1:0] b, input bit hold);
        acc_ok = 0; acc_r0 = 0; acc_r1 = 0; acc_cyc = -1; acc_ph = -1;
        if (id == 0) begin req0_a = a; req0_b = b; req0_valid = 1'b1; end
        else         begin req1_a = a; req1_b = b; req1_valid = 1'b1; end
        #1;
        for (int i = 0; i < 600 && !acc_ok; i++) begin
            if (req0_ready || req1_ready) begin
                acc_ok = 1; acc_r0 = req0_ready; acc_r1 = req1_ready;
                acc_cyc = cyc; acc_ph = int'(tb_ph);
            end else begin
                @(negedge clk);
            end
        end
        @(posedge clk); #1;
        if (id == 0) begin req0_a = ~a; req0_b = ~b; if (!hold) req0_valid = 1'b0; end
        else         begin req1_a = ~a; req1_b = ~b; if (!hold) req1_valid = 1'b0; end
    endtask

    // Observe the job from the cycle after accept up to res_valid.
    task automatic run_job();
        job_ok = 0; n_loads = 0; saw_ready = 0; ld_both = 0;
        ld_cyc = -1; ld_ph = -1; v_cyc = -1; ld_a = '0; ld_b = '0;
        for (int i = 0; i < 700 && !job_ok; i++) begin
            @(negedge clk);
            if (mul_loadA || mul_loadB) begin
                n_loads++; ld_cyc = cyc; ld_ph = int'(tb_ph);
                ld_a = mul_iA; ld_b = mul_iB; ld_both = mul_loadA && mul_loadB;
            end
            if (req0_ready || req1_ready) saw_ready = 1;
            if (res_valid) begin job_ok = 1; v_cyc = cyc; end
        end
    endtask

    task automatic take();
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
    endtask

    task automatic wait_ph(input int target);
        for (int i = 0; i < 300 && int'(tb_ph) != target; i++) @(negedge clk);
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        rst_n = 1'b0; res_ready = 1'b0; oc_mode = 1;
        req0_a = 4'd5; req0_b = 4'd7; req1_a = 4'd3; req1_b = 4'd9;
        req0_valid = 1'b1; req1_valid = 1'b1;
        repeat (3) @(negedge clk);
        n_vec++;
        if ({res_valid, res_id, mul_loadA, mul_loadB, req0_ready, req1_ready} !== 6'b0) begin
            n_err++; $display("FAIL reset_ctrl: got %b, expected 000000",
                {res_valid, res_id, mul_loadA, mul_loadB, req0_ready, req1_ready});
        end
        n_vec++;
        if (res_cnt !== 9'd0) begin n_err++; $display("FAIL reset_cnt: got %0d, expected 0", res_cnt); end
        n_vec++;
        if (res_prod !== 4'd0) begin n_err++; $display("FAIL reset_prod: got %0d, expected 0", res_prod); end
        n_vec++;
        if ({mul_iA, mul_iB} !== 8'h00) begin n_err++; $display("FAIL reset_ops: got %h, expected 00", {mul_iA, mul_iB}); end
        rst_n = 1'b1;   // released with both requesters already valid
    endtask

    task automatic test_arbitration();
        for (int j = 0; j < 4; j++) begin
            int exp_id = j % 2;
            logic [WIDTH-1:0] ea = (exp_id == 0) ? 4'd5 : 4'd3;
            logic [WIDTH-1:0] eb = (exp_id == 0) ? 4'd7 : 4'd9;
            issue(exp_id, ea, eb, 1'b1);
            n_vec++;
            if (!acc_ok || {acc_r0, acc_r1} !== ((exp_id == 0) ? 2'b10 : 2'b01)) begin
                n_err++; $display("FAIL arb_grant job %0d: got ready %b ok %0d, expected %b",
                    j, {acc_r0, acc_r1}, acc_ok, (exp_id == 0) ? 2'b10 : 2'b01);
            end
            run_job();
            n_vec++;
            if (!job_ok || res_id !== exp_id[0]) begin
                n_err++; $display("FAIL arb_id job %0d: got %0d ok %0d, expected %0d", j, res_id, job_ok, exp_id);
            end
            n_vec++;
            if ({ld_a, ld_b} !== {ea, eb}) begin
                n_err++; $display("FAIL arb_ops job %0d: got %h, expected %h", j, {ld_a, ld_b}, {ea, eb});
            end
            n_vec++;
            if (saw_ready !== 1'b0) begin
                n_err++; $display("FAIL arb_busy_ready job %0d: got 1, expected 0", j);
            end
            n_vec++;
            if (res_cnt !== 9'd256) begin
                n_err++; $display("FAIL arb_cnt job %0d: got %0d, expected 256", j, res_cnt);
            end
            take();
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
    endtask

    task automatic test_const_one();
        oc_mode = 1;
        issue(0, 4'd5, 4'd7, 1'b0);
        run_job();
        n_vec++;
        if (!acc_ok || !job_ok) begin n_err++; $display("FAIL c1_handshake: got acc %0d job %0d, expected 1 1", acc_ok, job_ok); end
        n_vec++;
        if (n_loads !== 1 || !ld_both) begin n_err++; $display("FAIL c1_load_pulse: got %0d both %0d, expected 1 1", n_loads, ld_both); end
        n_vec++;
        if (res_cnt !== 9'd256) begin n_err++; $display("FAIL c1_cnt: got %0d, expected 256", res_cnt); end
        n_vec++;
        if (res_prod !== 4'd15) begin n_err++; $display("FAIL c1_prod: got %0d, expected 15", res_prod); end
        n_vec++;
        if (res_id !== 1'b0) begin n_err++; $display("FAIL c1_id: got %0d, expected 0", res_id); end
        take();
        @(negedge clk);
        n_vec++;
        if (res_valid !== 1'b0) begin n_err++; $display("FAIL c1_valid_drop: got %0d, expected 0", res_valid); end
    endtask

    task automatic test_alternating();
        oc_mode = 2;
        issue(1, 4'hA, 4'h3, 1'b0);
        run_job();
        n_vec++;
        if (!job_ok || res_cnt !== 9'd128) begin n_err++; $display("FAIL alt_cnt: got %0d, expected 128", res_cnt); end
        n_vec++;
        if (res_prod !== 4'd8) begin n_err++; $display("FAIL alt_prod: got %0d, expected 8", res_prod); end
        n_vec++;
        if (res_id !== 1'b1) begin n_err++; $display("FAIL alt_id: got %0d, expected 1", res_id); end
        take();
        oc_mode = 0;
        issue(0, 4'h6, 4'h6, 1'b0);
        run_job();
        n_vec++;
        if (!job_ok || res_cnt !== 9'd0) begin n_err++; $display("FAIL zero_cnt: got %0d, expected 0", res_cnt); end
        n_vec++;
        if (res_prod !== 4'd0) begin n_err++; $display("FAIL zero_prod: got %0d, expected 0", res_prod); end
        take();
    endtask

    task automatic test_phase_alignment();
        oc_mode = 1;
        wait_ph(10);
        issue(0, 4'd5, 4'd7, 1'b0);
        run_job();
        n_vec++;
        if (acc_ph !== 10) begin n_err++; $display("FAIL ph10_accept_ph: got %0d, expected 10", acc_ph); end
        n_vec++;
        if (ld_ph !== 255 || n_loads !== 1) begin n_err++; $display("FAIL ph10_load_ph: got %0d loads %0d, expected 255 1", ld_ph, n_loads); end
        n_vec++;
        if (ld_cyc - acc_cyc !== 245) begin n_err++; $display("FAIL ph10_load_delay: got %0d, expected 245", ld_cyc - acc_cyc); end
        n_vec++;
        if ({ld_a, ld_b} !== 8'h57) begin n_err++; $display("FAIL ph10_ops: got %h, expected 57", {ld_a, ld_b}); end
        n_vec++;
        if (v_cyc - ld_cyc !== 257) begin n_err++; $display("FAIL ph10_latency: got %0d, expected 257", v_cyc - ld_cyc); end
        take();
        wait_ph(255);
        issue(0, 4'd5, 4'd7, 1'b0);
        run_job();
        n_vec++;
        if (acc_ph !== 255) begin n_err++; $display("FAIL ph255_accept_ph: got %0d, expected 255", acc_ph); end
        n_vec++;
        if (ld_cyc - acc_cyc !== 256) begin n_err++; $display("FAIL ph255_load_delay: got %0d, expected 256", ld_cyc - acc_cyc); end
        n_vec++;
        if (v_cyc - ld_cyc !== 257) begin n_err++; $display("FAIL ph255_latency: got %0d, expected 257", v_cyc - ld_cyc); end
        take();
    endtask

    task automatic test_backpressure();
        int hs_cyc;
        int exp_dly;
        oc_mode = 1;
        issue(1, 4'd6, 4'd2, 1'b0);
        run_job();
        req0_a = 4'd9; req0_b = 4'd4; req0_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            n_vec++;
            if ({res_valid, res_id, res_cnt, res_prod, req0_ready, req1_ready} !== {1'b1, 1'b1, 9'd256, 4'd15, 2'b00}) begin
                n_err++; $display("FAIL bp_hold cycle %0d: got %h, expected %h", i,
                    {res_valid, res_id, res_cnt, res_prod, req0_ready, req1_ready}, {1'b1, 1'b1, 9'd256, 4'd15, 2'b00});
            end
            @(negedge clk);
        end
        hs_cyc = cyc;
        n_vec++;
        if (req0_ready !== 1'b0) begin n_err++; $display("FAIL bp_hs_ready: got 1, expected 0"); end
        take();
        issue(0, 4'd9, 4'd4, 1'b0);
        run_job();
        exp_dly = (acc_ph == 255) ? 256 : 255 - acc_ph;
        n_vec++;
        if (acc_cyc !== hs_cyc + 1) begin n_err++; $display("FAIL bp_next_accept: got %0d, expected %0d", acc_cyc, hs_cyc + 1); end
        n_vec++;
        if (ld_ph !== 255 || ld_cyc - acc_cyc !== exp_dly) begin
            n_err++; $display("FAIL bp_next_load: got ph %0d delay %0d, expected 255 %0d", ld_ph, ld_cyc - acc_cyc, exp_dly);
        end
        n_vec++;
        if (!job_ok || res_id !== 1'b0 || {ld_a, ld_b} !== 8'h94) begin
            n_err++; $display("FAIL bp_next_job: got id %0d ops %h, expected 0 94", res_id, {ld_a, ld_b});
        end
        take();
    endtask

    task automatic test_reset_mid_run();
        bit seen_ld;
        bit late_valid;
        oc_mode = 1;
        issue(0, 4'd5, 4'd7, 1'b0);
        seen_ld = 0;
        for (int i = 0; i < 300 && !seen_ld; i++) begin
            @(negedge clk);
            if (mul_loadA) seen_ld = 1;
        end
        for (int i = 0; i < 300 && int'(tb_ph) != 100; i++) @(negedge clk);
        req0_valid = 1'b1;
        rst_n = 1'b0;
        #1;
        n_vec++;
        if (!seen_ld || {res_valid, res_id, res_cnt, res_prod, mul_loadA, mul_loadB, mul_iA, mul_iB,
             req0_ready, req1_ready} !== 27'd0) begin
            n_err++; $display("FAIL rst_run_outputs: got %h loadseen %0d, expected 0 1",
                {res_valid, res_id, res_cnt, res_prod, mul_loadA, mul_loadB, mul_iA, mul_iB, req0_ready, req1_ready}, seen_ld);
        end
        req0_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        late_valid = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (res_valid || mul_loadA) late_valid = 1;
        end
        n_vec++;
        if (late_valid !== 1'b0) begin n_err++; $display("FAIL rst_run_no_result: got 1, expected 0"); end
        oc_mode = 2;
        issue(0, 4'd2, 4'd3, 1'b0);
        run_job();
        n_vec++;
        if (!job_ok || res_cnt !== 9'd128 || res_prod !== 4'd8 || res_id !== 1'b0) begin
            n_err++; $display("FAIL rst_run_recover: got cnt %0d prod %0d id %0d, expected 128 8 0", res_cnt, res_prod, res_id);
        end
        n_vec++;
        if (ld_ph !== 255 || {ld_a, ld_b} !== 8'h23) begin
            n_err++; $display("FAIL rst_run_recover_load: got ph %0d ops %h, expected 255 23", ld_ph, {ld_a, ld_b});
        end
        take();
    endtask

    initial begin
        test_reset();
        test_arbitration();
        test_const_one();
        test_alternating();
        test_phase_alignment();
        test_backpressure();
        test_reset_mid_run();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
